if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage that sits directly downstream of the program counter register. It takes the current PC and its address-error flag and fetches the word over an SRAM-like instruction bus (req/addr_ok/data_ok). It presents a registered {valid, pc, inst, excp} bundle to ID. It drives `stallreq` while a fetch is outstanding, and it discards in-flight responses after a flush.

## Interface
- `ENT_RESET` — default 32'hBFC0_0000 — value of `if_pc` after reset.
- `clk` — in, 1 — clock, rising edge.
- `rst` — in, 1 — reset, asynchronous, active-high.
- `pc` — in, 32 — address to fetch; changes only on edges where the PC is not stalled.
- `pc_adel` — in, 1 — PC misaligned (`pc[1:0]!=0`).
- `flush` — in, 1 — exception/eret flush; `pc` is reloaded with the new address at the same edge.
- `id_stall` — in, 1 — ID holding; the output bundle must not change.
- `inst_req` — out, 1 — bus request.
- `inst_addr` — out, 32 — bus address, equal to `{pc[31:2],2'b00}`.
- `inst_addr_ok` — in, 1 — request accepted this cycle.
- `inst_rdata` — in, 32 — read data, valid with `inst_data_ok`.
- `inst_data_ok` — in, 1 — response, one per accepted request, in order.
- `stallreq` — out, 1 — fetch not complete; the PC must hold.
- `if_valid` — out, 1 — bundle to ID is a real instruction.
- `if_pc` — out, 32 — PC of the bundle.
- `if_inst` — out, 32 — instruction word.
- `if_adel` — out, 1 — instruction address error for this bundle.

## Operation
- States:
  - `REQ`: issue a request.
  - `DATA`: wait for the response.
  - `HOLD`: response captured, ID stalled.
  - `DROP`: discard the response of a flushed fetch.
- Internal completion signal: `done = (REQ & pc_adel) | (DATA & inst_data_ok) | HOLD`.
- `stallreq = ~done`.
- `REQ`:
  - `inst_req = ~pc_adel`.
  - With `pc_adel`: no bus access; the fetch completes with `inst=0`, `adel=1`.
  - With `inst_addr_ok & flush`: go to `DROP`.
  - With `inst_addr_ok` and no flush: go to `DATA`.
  - With `flush` but no `inst_addr_ok`: stay in `REQ`. Next cycle presents the new `pc`. This is legal because no handshake completed.
- `DATA`: `inst_req=0`.
  - With `inst_data_ok`: capture `inst_rdata` into the buffer.
    - `flush` → `REQ`.
    - else `id_stall` → `HOLD`.
    - else → `REQ`.
  - With `flush` and no `inst_data_ok`: go to `DROP`.
- `HOLD`: the buffer is stable.
  - `flush` → `REQ`, buffer dropped.
  - `~id_stall` → `REQ`.
- `DROP`: `inst_req=0`, `stallreq=1`.
  - On `inst_data_ok`: data ignored, go to `REQ`.
  - A further `flush` while in `DROP` stays in `DROP`. Only one response is outstanding.
- Output register update, evaluated at each edge in priority order:
  1. `flush`: `if_valid<=0`; pc/inst/adel may take any value.
  2. `id_stall`: hold all outputs.
  3. Otherwise: `if_valid<=done`. When `done`, load `if_pc<=pc`, `if_inst` (from `inst_rdata` in `DATA`, from the buffer in `HOLD`, 0 in the `pc_adel` case) and `if_adel<=pc_adel`.
- A `~done & ~id_stall` edge inserts a bubble (`if_valid=0`).
- At most one request is outstanding. A new request is never issued before its predecessor's `data_ok`.

## Timing
- Reset values: state=`REQ`, `if_valid=0`, `if_pc=ENT_RESET`, `if_inst=0`, `if_adel=0`.
- While `rst` is high: `inst_req=0`, `stallreq=1`.
- `inst_req`, `inst_addr` and `stallreq` are combinational from state and inputs.
- The bus guarantees `inst_data_ok` no earlier than the cycle after `inst_addr_ok`. `data_ok` seen in `REQ` is ignored.
- Minimum latency, with `addr_ok` in cycle 0 and `data_ok` in cycle 1: `if_valid` rises after edge 2. Throughput is one instruction per 2 cycles.
- `pc_adel` fetch: completes in the same cycle; `if_valid=1`, `if_adel=1` after the next edge.
- `rst` mid-transaction: return to `REQ` immediately. The pending bus response is the bus's responsibility; the bus is reset together with this block.

## Test plan
- Zero-wait bus, `pc=0xBFC00000`, `addr_ok` cycle 0, `data_ok`+`0x24080001` cycle 1 → `stallreq` high cycle 0 and low cycle 1; after edge 2, `if_valid=1`, `if_pc=0xBFC00000`, `if_inst=0x24080001`.
- `addr_ok` delayed 3 cycles, `data_ok` delayed 2 more → `inst_req` held high 4 cycles with constant `inst_addr`; `if_valid=0` bubbles throughout; a single valid bundle afterwards.
- `id_stall` high 3 cycles across `data_ok` → enters `HOLD`; outputs frozen; no new `inst_req`; the captured word appears the edge after `id_stall` falls.
- `flush` in `DATA` before `data_ok`, `pc` switches to `0xBFC00380` → `DROP`; the late response with `0xDEADBEEF` never reaches `if_inst`; the next request uses `0xBFC00380`; `if_valid=0` until it completes.
- `pc=0xBFC00002` (`pc_adel=1`) → `inst_req` stays 0; next edge `if_valid=1`, `if_adel=1`, `if_inst=0`.
- `rst` asserted in `DATA` → `if_valid=0`, `if_pc=ENT_RESET` immediately; after release, the fetch restarts in `REQ`.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetches the word at the PC over an SRAM-like bus
// and presents a registered {valid, pc, inst, adel} bundle to ID.
module if_fetch #(
    parameter logic [31:0] ENT_RESET = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_adel,
    input  logic        flush,
    input  logic        id_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        stallreq,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] inst_buf;
    logic        done;
    logic [31:0] done_inst;

    always_comb begin
        done      = 1'b0;
        done_inst = 32'h0;
        inst_req  = 1'b0;
        case (state)
            REQ: begin
                inst_req = ~pc_adel;
                done     = pc_adel;
            end
            DATA: begin
                done      = inst_data_ok;
                done_inst = inst_rdata;
            end
            HOLD: begin
                done      = 1'b1;
                done_inst = inst_buf;
            end
            default: begin
                done = 1'b0;
            end
        endcase
        // Bus and PC stay quiet for the whole reset pulse.
        if (rst) begin
            inst_req = 1'b0;
            done     = 1'b0;
        end
        stallreq = ~done;
    end

    assign inst_addr = {pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            if_valid <= 1'b0;
            if_pc    <= ENT_RESET;
            if_inst  <= 32'h0;
            if_adel  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (~pc_adel & inst_addr_ok)
                        state <= flush ? DROP : DATA;
                end
                DATA: begin
                    if (inst_data_ok)
                        state <= (~flush & id_stall) ? HOLD : REQ;
                    else if (flush)
                        state <= DROP;
                end
                HOLD: begin
                    if (flush | ~id_stall)
                        state <= REQ;
                end
                DROP: begin
                    // Only one response can be in flight, so a repeated flush changes nothing.
                    if (inst_data_ok)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase

            if (flush) begin
                if_valid <= 1'b0;
            end else if (~id_stall) begin
                if_valid <= done;
                if (done) begin
                    if_pc   <= pc;
                    if_inst <= done_inst;
                    if_adel <= pc_adel;
                end
            end
        end
    end

    // Response captured while ID is stalled; replayed from HOLD.
    always_ff @(posedge clk) begin
        if (state == DATA && inst_data_ok)
            inst_buf <= inst_rdata;
    end

endmodule
